// File: rtl/watch_pkg.sv
// rtl/watch_pkg.sv - shared state codes and depth helper for the watch capture controller
//
// Purpose: state encoding of the capture/readout FSM and the capture-RAM depth
// derivation, shared by every file of the watch capture slice.
// Ports: none (package).

package watch_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE     = 3'd0,
    S_PRE      = 3'd1,
    S_ARMED    = 3'd2,
    S_POST     = 3'd3,
    S_DONE     = 3'd4,
    S_RD_ISSUE = 3'd5,
    S_RD_HOLD  = 3'd6
  } state_t;

  // Capture-RAM depth for a given address width.
  function automatic int watch_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/watch_capture_ctrl_if.sv
// rtl/watch_capture_ctrl_if.sv - capture-RAM and readout-stream bundle
//
// Purpose: groups the capture-RAM write/read port and the readout stream.
// Signals:
//   wt_en/wt_addr      capture-RAM write strobe and address (controller -> RAM)
//   rd_en/rd_addr      capture-RAM read strobe and address  (controller -> RAM)
//   rd_data            read data, valid one cycle after rd_en (RAM -> controller)
//   out_valid/out_data readout stream                        (controller -> sink)
//   out_ready          downstream ready                      (sink -> controller)
// Modports: master = controller side, slave = RAM/sink side.

interface watch_capture_ctrl_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
);

  logic              wt_en;
  logic [ADDR_W-1:0] wt_addr;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;

  modport master (
    output wt_en, wt_addr, rd_en, rd_addr, out_valid, out_data,
    input  rd_data, out_ready
  );

  modport slave (
    input  wt_en, wt_addr, rd_en, rd_addr, out_valid, out_data,
    output rd_data, out_ready
  );

endinterface

// File: rtl/watch_rd_hold.sv
// rtl/watch_rd_hold.sv - readout output register with valid/ready hold
//
// Purpose: captures one RAM read word and presents it on a valid/ready stream,
// keeping data stable until the sink accepts it.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   clear      drops valid immediately (abort)
//   load       capture in_data and raise valid
//   in_data    RAM read data
//   out_ready  downstream ready
//   out_valid  stream valid
//   out_data   stream data (registered)

module watch_rd_hold #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load,
  input  logic [DATA_W-1:0] in_data,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      data_d  = in_data;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/watch_capture_ctrl.sv
// rtl/watch_capture_ctrl.sv - pre/post-trigger capture and circular readout controller
//
// Purpose: fills a circular capture RAM before a trigger, records the trigger
// address, stops after post_len samples, then streams the whole buffer out
// oldest-first.
// Ports:
//   trig_clk, trig_rst  clock, synchronous active-high reset
//   arm                 pulse: start capture (IDLE/DONE only)
//   abort               level: return to IDLE, highest priority
//   pause               level: freeze writes and counters during capture
//   trig_hit            trigger condition (ARMED only)
//   post_len            post-trigger sample count incl. trigger, latched on arm
//   rd_start            pulse: start readout from DONE
//   rd_done             pulse after the last readout beat
//   stop_flag/stop_addr capture complete / last written address
//   trig_addr           address of the trigger sample
//   state               FSM state code
//   bus                 capture-RAM port and readout stream (master)

module watch_capture_ctrl
  import watch_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic                trig_clk,
  input  logic                trig_rst,
  input  logic                arm,
  input  logic                abort,
  input  logic                pause,
  input  logic                trig_hit,
  input  logic [ADDR_W-1:0]   post_len,
  input  logic                rd_start,
  output logic                rd_done,
  output logic                stop_flag,
  output logic [ADDR_W-1:0]   stop_addr,
  output logic [ADDR_W-1:0]   trig_addr,
  output logic [STATE_W-1:0]  state,
  watch_capture_ctrl_if.master bus
);

  localparam int               CNT_W   = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(watch_depth(ADDR_W));

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wt_addr_q, wt_addr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
  logic [ADDR_W-1:0] stop_addr_q, stop_addr_d;
  logic [ADDR_W-1:0] post_len_q, post_len_d;
  // One counter serves all phases: writes done in PRE, post-trigger samples
  // (trigger included) in POST, beats remaining during readout.
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              stop_flag_q, stop_flag_d;
  logic              rd_done_q, rd_done_d;
  // High in the first RD_HOLD cycle, when the RAM word from RD_ISSUE is valid.
  logic              load_q, load_d;

  logic              capturing;
  logic              wr_fire;
  logic              rd_fire;
  logic [CNT_W-1:0]  cnt_inc;
  logic [CNT_W-1:0]  pre_len;
  logic              hold_valid;
  logic [DATA_W-1:0] hold_data;

  assign capturing = (state_q == S_PRE) || (state_q == S_ARMED) || (state_q == S_POST);
  assign wr_fire   = capturing && !pause;
  assign rd_fire   = hold_valid && bus.out_ready;
  assign cnt_inc   = cnt_q + CNT_W'(1);
  assign pre_len   = DEPTH_C - {1'b0, post_len_q};

  always_comb begin
    state_d     = state_q;
    wt_addr_d   = wt_addr_q;
    rd_ptr_d    = rd_ptr_q;
    trig_addr_d = trig_addr_q;
    stop_addr_d = stop_addr_q;
    post_len_d  = post_len_q;
    cnt_d       = cnt_q;
    stop_flag_d = stop_flag_q;
    rd_done_d   = 1'b0;
    load_d      = 1'b0;

    if (abort) begin
      state_d     = S_IDLE;
      stop_flag_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (arm) begin
            state_d     = S_PRE;
            wt_addr_d   = '0;
            cnt_d       = '0;
            stop_flag_d = 1'b0;
            post_len_d  = (post_len == '0) ? ADDR_W'(1) : post_len;
          end else if ((state_q == S_DONE) && rd_start) begin
            // Oldest sample sits just after the last written address.
            state_d  = S_RD_ISSUE;
            rd_ptr_d = stop_addr_q + ADDR_W'(1);
            cnt_d    = DEPTH_C;
          end
        end

        S_PRE: begin
          if (wr_fire) begin
            wt_addr_d = wt_addr_q + ADDR_W'(1);
            cnt_d     = cnt_inc;
            if (cnt_inc == pre_len) begin
              state_d = S_ARMED;
              cnt_d   = '0;
            end
          end
        end

        S_ARMED: begin
          if (wr_fire) begin
            wt_addr_d = wt_addr_q + ADDR_W'(1);
            if (trig_hit) begin
              trig_addr_d = wt_addr_q;
              if (post_len_q == ADDR_W'(1)) begin
                state_d     = S_DONE;
                stop_addr_d = wt_addr_q;
                stop_flag_d = 1'b1;
              end else begin
                state_d = S_POST;
                cnt_d   = CNT_W'(1);
              end
            end
          end
        end

        S_POST: begin
          if (wr_fire) begin
            wt_addr_d = wt_addr_q + ADDR_W'(1);
            cnt_d     = cnt_inc;
            if (cnt_inc == {1'b0, post_len_q}) begin
              state_d     = S_DONE;
              stop_addr_d = wt_addr_q;
              stop_flag_d = 1'b1;
            end
          end
        end

        S_RD_ISSUE: begin
          state_d = S_RD_HOLD;
          load_d  = 1'b1;
        end

        S_RD_HOLD: begin
          if (rd_fire) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
            cnt_d    = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              state_d   = S_DONE;
              rd_done_d = 1'b1;
            end else begin
              state_d = S_RD_ISSUE;
            end
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge trig_clk) begin
    if (trig_rst) begin
      state_q     <= S_IDLE;
      wt_addr_q   <= '0;
      rd_ptr_q    <= '0;
      trig_addr_q <= '0;
      stop_addr_q <= '0;
      post_len_q  <= '0;
      cnt_q       <= '0;
      stop_flag_q <= 1'b0;
      rd_done_q   <= 1'b0;
      load_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wt_addr_q   <= wt_addr_d;
      rd_ptr_q    <= rd_ptr_d;
      trig_addr_q <= trig_addr_d;
      stop_addr_q <= stop_addr_d;
      post_len_q  <= post_len_d;
      cnt_q       <= cnt_d;
      stop_flag_q <= stop_flag_d;
      rd_done_q   <= rd_done_d;
      load_q      <= load_d;
    end
  end

  watch_rd_hold #(
    .DATA_W (DATA_W)
  ) u_rd_hold (
    .clk       (trig_clk),
    .rst       (trig_rst),
    .clear     (abort),
    .load      (load_q),
    .in_data   (bus.rd_data),
    .out_ready (bus.out_ready),
    .out_valid (hold_valid),
    .out_data  (hold_data)
  );

  assign bus.wt_en     = wr_fire;
  assign bus.wt_addr   = wt_addr_q;
  assign bus.rd_en     = (state_q == S_RD_ISSUE);
  assign bus.rd_addr   = rd_ptr_q;
  assign bus.out_valid = hold_valid;
  assign bus.out_data  = hold_data;
  assign rd_done       = rd_done_q;
  assign stop_flag     = stop_flag_q;
  assign stop_addr     = stop_addr_q;
  assign trig_addr     = trig_addr_q;
  assign state         = state_q;

endmodule

// File: tb/tb_watch_capture_ctrl.sv
// tb/tb_watch_capture_ctrl.sv - directed table-driven bench for watch_capture_ctrl

module tb_watch_capture_ctrl;

  logic       clk = 1'b0;
  logic       trig_rst, arm, abort, pause, trig_hit, rd_start;
  logic [3:0] post_len;
  logic       rd_done, stop_flag;
  logic [3:0] stop_addr, trig_addr;
  logic [2:0] state;

  int n_cmp = 0;
  int n_err = 0;

  int          wr_num = 0;
  logic [15:0] mem [16];

  typedef struct {
    logic [3:0] post_len;
    int         trig_idx;
    int         pause_at;
    logic [3:0] exp_trig;
    logic [3:0] exp_stop;
    int         exp_writes;
  } vec_t;

  vec_t vecs [7];

  watch_capture_ctrl_if #(.ADDR_W(4), .DATA_W(16)) bus ();

  watch_capture_ctrl #(.ADDR_W(4), .DATA_W(16)) dut (
    .trig_clk  (clk),
    .trig_rst  (trig_rst),
    .arm       (arm),
    .abort     (abort),
    .pause     (pause),
    .trig_hit  (trig_hit),
    .post_len  (post_len),
    .rd_start  (rd_start),
    .rd_done   (rd_done),
    .stop_flag (stop_flag),
    .stop_addr (stop_addr),
    .trig_addr (trig_addr),
    .state     (state),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // Capture RAM model: each write stores its running sample number.
  always @(posedge clk) begin
    if (bus.wt_en) begin
      mem[bus.wt_addr] <= 16'(wr_num + 1);
      wr_num <= wr_num + 1;
    end
    if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_state"},     state, 0);
    chk({tag, "_wt_en"},     bus.wt_en, 0);
    chk({tag, "_wt_addr"},   bus.wt_addr, 0);
    chk({tag, "_rd_en"},     bus.rd_en, 0);
    chk({tag, "_rd_addr"},   bus.rd_addr, 0);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_out_data"},  bus.out_data, 0);
    chk({tag, "_rd_done"},   rd_done, 0);
    chk({tag, "_stop_flag"}, stop_flag, 0);
    chk({tag, "_stop_addr"}, stop_addr, 0);
    chk({tag, "_trig_addr"}, trig_addr, 0);
  endtask

  task automatic run_entry(input vec_t v, output int base);
    int         n;
    int         pause_left;
    bit         pause_done;
    bit         done;
    logic [3:0] hold_addr;
    base       = wr_num;
    pause_left = 0;
    pause_done = 0;
    done       = 0;
    hold_addr  = '0;
    @(negedge clk);
    arm      = 1'b1;
    post_len = v.post_len;
    @(negedge clk);
    arm      = 1'b0;
    post_len = ~v.post_len;
    for (int c = 0; c < 200 && !done; c++) begin
      if (state == 3'd4) begin
        done = 1;
      end else begin
        n = wr_num - base;
        if (pause_left > 0) begin
          pause = 1'b1;
          pause_left--;
        end else if (v.pause_at != 0 && !pause_done && n == v.pause_at) begin
          pause      = 1'b1;
          pause_left = 4;
          pause_done = 1;
          hold_addr  = bus.wt_addr;
        end else begin
          pause = 1'b0;
        end
        trig_hit = (n + 1 == 3) || (n + 1 >= v.trig_idx);
        #1;
        if (pause) begin
          chk("pause_wt_en", bus.wt_en, 0);
          chk("pause_wt_addr", bus.wt_addr, hold_addr);
        end
        @(negedge clk);
      end
    end
    pause    = 1'b0;
    trig_hit = 1'b0;
    chk("capture_reached_done", done, 1);
    chk("trig_addr", trig_addr, v.exp_trig);
    chk("stop_addr", stop_addr, v.exp_stop);
    chk("stop_flag", stop_flag, 1);
    chk("write_count", wr_num - base, v.exp_writes);
    chk("done_wt_en", bus.wt_en, 0);
  endtask

  task automatic do_readout(input logic [3:0] first_addr, input int first_data, input int stall_beat);
    int          beats, rd_cnt, done_cnt, stall, stall_rd;
    bit          stalling;
    logic [15:0] held;
    logic [3:0]  exp_addr;
    beats = 0; rd_cnt = 0; done_cnt = 0; stall = 0; stall_rd = 0;
    stalling = 0;
    held = '0;
    bus.out_ready = 1'b1;
    rd_start = 1'b1;
    @(negedge clk);
    rd_start = 1'b0;
    for (int c = 0; c < 75; c++) begin
      if (bus.rd_en) begin
        exp_addr = first_addr + 4'(rd_cnt);
        chk("rd_addr", bus.rd_addr, exp_addr);
        rd_cnt++;
        if (stalling) stall_rd++;
      end
      if (rd_done) done_cnt++;
      if (bus.out_valid) begin
        if (beats == stall_beat && stall < 3) begin
          if (stall == 0) held = bus.out_data;
          else chk("stall_data", bus.out_data, held);
          bus.out_ready = 1'b0;
          stalling = 1;
          stall++;
        end else begin
          bus.out_ready = 1'b1;
          stalling = 0;
          chk("beat_data", bus.out_data, 16'(first_data + beats));
          beats++;
        end
      end
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    chk("beat_count", beats, 16);
    chk("rd_en_count", rd_cnt, 16);
    chk("rd_done_count", done_cnt, 1);
    chk("rd_en_during_stall", stall_rd, 0);
    chk("readout_end_state", state, 4);
  endtask

  initial begin
    int  base;
    bit  seen;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    trig_rst = 1'b1; arm = 1'b0; abort = 1'b0; pause = 1'b0;
    trig_hit = 1'b0; rd_start = 1'b0; post_len = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    trig_rst = 1'b0;

    //           post  trig pause trig   stop   writes
    vecs[0] = '{4'd4,  13,  0,   4'd12, 4'd15, 16};
    vecs[1] = '{4'd4,  22,  0,   4'd5,  4'd8,  25};
    vecs[2] = '{4'd0,  16,  0,   4'd15, 4'd15, 16};
    vecs[3] = '{4'd1,  20,  0,   4'd3,  4'd3,  20};
    vecs[4] = '{4'd15, 2,   0,   4'd1,  4'd15, 16};
    vecs[5] = '{4'd8,  30,  0,   4'd13, 4'd4,  37};
    vecs[6] = '{4'd4,  22,  23,  4'd5,  4'd8,  25};

    for (int i = 0; i < 7; i++) run_entry(vecs[i], base);

    // Readout with a 3-cycle stall on beat 2, then an unstalled repeat.
    run_entry(vecs[1], base);
    do_readout(4'd9, base + 10, 2);
    do_readout(4'd9, base + 10, -1);

    // arm beats rd_start in DONE.
    @(negedge clk);
    arm = 1'b1; rd_start = 1'b1; post_len = 4'd4;
    @(negedge clk);
    arm = 1'b0; rd_start = 1'b0;
    chk("arm_wins_state", state, 1);
    chk("arm_clears_stop_flag", stop_flag, 0);

    // Abort in POST.
    trig_hit = 1'b1;
    seen = 0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (state == 3'd3) seen = 1;
    end
    chk("reach_post", seen, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0; trig_hit = 1'b0;
    chk("abort_post_state", state, 0);
    chk("abort_post_stop_flag", stop_flag, 0);
    chk("abort_post_wt_en", bus.wt_en, 0);

    // Abort in DONE drops stop_flag.
    run_entry(vecs[0], base);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_done_state", state, 0);
    chk("abort_done_stop_flag", stop_flag, 0);

    // Reset during RD_HOLD.
    run_entry(vecs[1], base);
    rd_start = 1'b1;
    @(negedge clk);
    rd_start = 1'b0;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      if (state == 3'd6) seen = 1;
      else @(negedge clk);
    end
    chk("reach_rd_hold", seen, 1);
    trig_rst = 1'b1;
    @(negedge clk);
    chk_zero("rst_rd_hold");
    trig_rst = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
